// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs first-word-fall-through FIFO entries into wide words with byte-lane keep
// Optional idle auto-flush is enabled by defining FIFO_PACK_TIMEOUT_EN.
module fifo_rd_packer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PACK_RATIO     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_rempty,
    input  logic [DATA_WIDTH-1:0]              i_rdata,
    output logic                               o_rinc,
    input  logic                               i_flush,
    output logic [DATA_WIDTH*PACK_RATIO-1:0]   o_tdata,
    output logic [PACK_RATIO-1:0]              o_tkeep,
    output logic                               o_tvalid,
    input  logic                               i_tready,
    output logic [$clog2(PACK_RATIO+1)-1:0]    o_acc_cnt
);
    localparam int CNT_W = $clog2(PACK_RATIO + 1);
    localparam int OUT_W = DATA_WIDTH * PACK_RATIO;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK_RATIO - 1);

    logic [CNT_W-1:0]      r_acc_cnt;
    logic [OUT_W-1:0]      r_acc;
    logic                  r_flush_pend;
    logic [OUT_W-1:0]      r_tdata;
    logic [PACK_RATIO-1:0] r_tkeep;
    logic                  r_tvalid;

    logic                  w_out_free;
    logic                  w_flush_go;
    logic                  w_pop;
    logic                  w_complete;
    logic                  w_pend_set;
    logic [PACK_RATIO-1:0] w_part_keep;

    assign w_out_free = !r_tvalid || i_tready;
    assign w_flush_go = r_flush_pend && (r_acc_cnt != '0) && w_out_free;
    // A pop that would complete a word waits until the output register can take it.
    assign w_pop      = i_rst_n && !i_rempty && !w_flush_go &&
                        ((r_acc_cnt < LAST_LANE) || w_out_free);
    assign w_complete = w_pop && (r_acc_cnt == LAST_LANE);
    assign o_rinc     = w_pop;

    always_comb begin
        w_part_keep = '0;
        for (int i = 0; i < PACK_RATIO; i++) begin
            w_part_keep[i] = (CNT_W'(i) < r_acc_cnt);
        end
    end

`ifdef FIFO_PACK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic              w_idle_inc;

    assign w_idle_inc = (r_acc_cnt != '0) && !w_pop && (r_idle_cnt != IDLE_MAX);
    // The flush request rises together with the count reaching the limit.
    assign w_pend_set = i_flush || (w_idle_inc && (r_idle_cnt == IDLE_LAST));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idle_cnt <= '0;
        end else if (w_pop || w_flush_go) begin
            r_idle_cnt <= '0;
        end else if (w_idle_inc) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_pend_set = i_flush;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flush_pend <= 1'b0;
        end else if (w_flush_go) begin
            r_flush_pend <= 1'b0;
        end else if (w_pend_set) begin
            r_flush_pend <= 1'b1;
        end else if (r_acc_cnt == '0) begin
            r_flush_pend <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
        end else if (w_complete || w_flush_go) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
        end else if (w_pop) begin
            for (int i = 0; i < PACK_RATIO; i++) begin
                if (CNT_W'(i) == r_acc_cnt) begin
                    r_acc[i*DATA_WIDTH +: DATA_WIDTH] <= i_rdata;
                end
            end
            r_acc_cnt <= r_acc_cnt + 1'b1;
        end
    end

    // The last lane is never stored; the completing entry goes straight to the output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tvalid <= 1'b0;
        end else if (w_complete) begin
            r_tdata  <= {i_rdata, r_acc[OUT_W-DATA_WIDTH-1:0]};
            r_tkeep  <= '1;
            r_tvalid <= 1'b1;
        end else if (w_flush_go) begin
            r_tdata  <= r_acc;
            r_tkeep  <= w_part_keep;
            r_tvalid <= 1'b1;
        end else if (i_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign o_tdata   = r_tdata;
    assign o_tkeep   = r_tkeep;
    assign o_tvalid  = r_tvalid;
    assign o_acc_cnt = r_acc_cnt;

endmodule
